mau_dbuf: RTL and testbench
===========================

Name: mau_dbuf

Overview:
- Next-generation systolic multiply-accumulate PE for the weight-stationary array.
- Parametrised data and accumulator widths, with runtime signed/unsigned multiply.
- Double-buffered weights: a column can stream the next weight set into the shadow bank while the active bank keeps multiplying, then swap with zero bubble.
- Image, weight and swap all forward to the neighbour PE with one-cycle registered latency.

Parameters:
- DATA_W, 8, image/weight width; must be >= 2.
- ACC_W, 32, accumulator width; must be >= 2*DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- signed_mode  in  1  1 = two's-complement multiply; 0 = unsigned.
- in_image  in  DATA_W  image operand.
- in_image_load  in  1  image valid.
- in_weight  in  DATA_W  weight on the column shift chain.
- in_weight_load  in  1  weight valid.
- in_weight_swap  in  1  request to promote shadow bank to active.
- acc_in  in  ACC_W  partial sum from upstream PE.
- out_image  out  DATA_W  registered image forward.
- out_image_load  out  1  registered image valid.
- out_weight  out  DATA_W  displaced shadow weight forwarded down the chain.
- out_weight_load  out  1  forwarded weight valid.
- out_weight_swap  out  1  in_weight_swap delayed one cycle.
- acc_out  out  ACC_W  registered partial sum.
- acc_out_valid  out  1  acc_out qualifier.
- swap_err  out  1  one-cycle pulse on an illegal swap.
- sat_flag  out  1  one-cycle pulse when saturation clipped the result.
- weight_state  out  2  weight FSM state.

Behaviour:
Reset:
- rst is synchronous; all registers clear on the rising clk edge where rst=1.
- Every output resets to 0; weight_state resets to EMPTY.
- Both weight banks clear and bank_sel resets to 0.
- Reset mid-stream discards in-flight data; the same-cycle load and swap are ignored.

Weight FSM (weight_state encoding):
- EMPTY=0: no active weight, no shadow weight.
- SHADOW=1: shadow weight valid only.
- ACTIVE=2: active weight valid only.
- FULL=3: both valid.

Weight load:
- in_weight_load=1 writes in_weight into the inactive bank (bank !bank_sel).
- If the shadow bank was already valid, the old shadow value goes to out_weight and out_weight_load=1 next cycle (shift-chain behaviour). Otherwise out_weight_load=0 and out_weight=0.
- Transitions: EMPTY->SHADOW, ACTIVE->FULL; SHADOW and FULL stay where they are.

Swap:
- in_weight_swap=1 toggles bank_sel at the clock edge.
- Transitions: SHADOW->ACTIVE, FULL->ACTIVE (the old active weight is discarded).
- Swap in EMPTY or ACTIVE is illegal: no toggle, swap_err=1 next cycle, state unchanged, out_weight_swap still forwards.
- Load and swap in the same cycle: the weight is written to the inactive bank first, then the toggle happens, so the new weight becomes active. From EMPTY or ACTIVE this is legal and yields ACTIVE.

Multiply-accumulate:
- Operands: in_image times the active bank.
- signed_mode=1: operands sign-extended. signed_mode=0: operands zero-extended.
- Product is 2*DATA_W bits, extended to ACC_W per the same mode, then added to acc_in.
- An image in the same cycle as a swap uses the pre-swap active weight.
- acc_out_valid: asserted 1 cycle after in_image_load=1 when state is ACTIVE or FULL.
- acc_out when not valid:
  - in_image_load=1 in EMPTY or SHADOW: acc_out=acc_in, acc_out_valid=0 (product treated as 0).
  - in_image_load=0: acc_out=0.

Forwarding and concurrency:
- out_image and out_image_load are in_image and in_image_load delayed 1 cycle; out_image=0 when not loading.
- Image, weight load and swap may all be asserted together; there is no error state for concurrent image and weight loads.

Latency:
- acc_out, out_image, out_weight and out_weight_swap: 1 cycle.
- A swap takes effect for images presented the cycle after the swap.

Arithmetic:
- Without the optional feature the sum wraps modulo 2^ACC_W.

Optional Feature:
- Macro: MAU_DBUF_SAT_EN.
- Defined: the sum is computed at ACC_W+1 bits.
  - signed_mode=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - signed_mode=0: clamp to 2^ACC_W-1.
  - sat_flag=1 on the cycle acc_out carries a clamped value.
- Undefined: wrap-around arithmetic and sat_flag tied to 0.

Test Plan:
- Reset/load/swap/multiply: rst 2 cycles, load weight 3, swap, then image 5 with acc_in=10 -> acc_out=25, acc_out_valid=1 one cycle later; weight_state EMPTY->SHADOW->ACTIVE.
- Zero-bubble swap: active=2, stream shadow=7 while images 1,1,1 stream with acc_in=0; swap coincident with the 3rd image -> acc_out 2,2,2, then image 1 -> 7.
- Weight chain: load 4 then 9 without a swap -> second load gives out_weight=4, out_weight_load=1; state stays SHADOW.
- Illegal swap: swap in EMPTY -> swap_err pulse, state EMPTY, acc_out_valid=0 for image 5 with acc_in=3 (acc_out=3).
- Signed mode (DATA_W=8): weight 0xFF, image 0x02, acc_in=0 -> signed_mode=1 gives 0xFFFFFFFE; signed_mode=0 gives 0x000001FE.
- With MAU_DBUF_SAT_EN: acc_in=0x7FFFFFFF, weight 1, image 1, signed -> acc_out=0x7FFFFFFF, sat_flag=1. Without the macro -> 0x80000000, sat_flag=0.

Source files
------------

// File: rtl/mau_dbuf.sv
// mau_dbuf: weight-stationary systolic MAC processing element with
// double-buffered weights (active and shadow banks) and zero-bubble swap.
// Image, weight and swap controls forward to the neighbour PE one cycle later.
// Optional build macro MAU_DBUF_SAT_EN: when defined, the accumulate clamps to
// the ACC_W range and raises sat_flag; when undefined, the sum wraps modulo
// 2^ACC_W and sat_flag is held at 0.
module mau_dbuf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] in_image,
  input  logic              in_image_load,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_weight_load,
  input  logic              in_weight_swap,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [DATA_W-1:0] out_image,
  output logic              out_image_load,
  output logic [DATA_W-1:0] out_weight,
  output logic              out_weight_load,
  output logic              out_weight_swap,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_out_valid,
  output logic              swap_err,
  output logic              sat_flag,
  output logic [1:0]        weight_state
);

  localparam int unsigned PROD_W = 2 * DATA_W;
`ifdef MAU_DBUF_SAT_EN
  // One guard bit above the accumulator detects overflow.
  localparam int unsigned SUM_W = ACC_W + 1;
`else
  localparam int unsigned SUM_W = ACC_W;
`endif

  typedef enum logic [1:0] {
    W_EMPTY  = 2'd0,
    W_SHADOW = 2'd1,
    W_ACTIVE = 2'd2,
    W_FULL   = 2'd3
  } wstate_e;

  // Weight storage and FSM state
  wstate_e            state_q;
  logic               bank_sel_q;
  logic [DATA_W-1:0]  bank0_q;
  logic [DATA_W-1:0]  bank1_q;

  // Registered outputs
  logic [DATA_W-1:0]  out_image_q;
  logic               out_image_load_q;
  logic [DATA_W-1:0]  out_weight_q;
  logic               out_weight_load_q;
  logic               out_weight_swap_q;
  logic [ACC_W-1:0]   acc_out_q;
  logic               acc_out_valid_q;
  logic               swap_err_q;
  logic               sat_flag_q;

  // Next-state values for the datapath registers
  logic [ACC_W-1:0]   acc_d;
  logic               acc_valid_d;
  logic               sat_d;
  logic [DATA_W-1:0]  out_weight_d;
  logic               out_weight_load_d;

  // Decode helpers
  logic [DATA_W-1:0]  active_w;
  logic [DATA_W-1:0]  shadow_w;
  logic               act_valid;
  logic               shd_valid;
  logic               swap_ok;
  logic               swap_bad;

  // Multiply-accumulate intermediates
  logic [PROD_W-1:0]  img_x;
  logic [PROD_W-1:0]  wgt_x;
  logic [PROD_W-1:0]  prod;
  logic [SUM_W-1:0]   prod_ext;
  logic [SUM_W-1:0]   acc_ext;
  logic [SUM_W-1:0]   sum;
  logic [ACC_W-1:0]   mac_res;
  logic               mac_sat;

  // Bank selection and legality of the requested swap
  always_comb begin
    active_w  = bank_sel_q ? bank1_q : bank0_q;
    shadow_w  = bank_sel_q ? bank0_q : bank1_q;
    act_valid = (state_q == W_ACTIVE) || (state_q == W_FULL);
    shd_valid = (state_q == W_SHADOW) || (state_q == W_FULL);
    // A same-cycle load fills the shadow first, so the swap is always legal then.
    swap_ok   = in_weight_swap && (in_weight_load || shd_valid);
    swap_bad  = in_weight_swap && !swap_ok;
  end

  // Product and sum with mode-dependent operand extension
  always_comb begin
    img_x = {{DATA_W{signed_mode & in_image[DATA_W-1]}}, in_image};
    wgt_x = {{DATA_W{signed_mode & active_w[DATA_W-1]}}, active_w};
    // Low PROD_W bits of the product are exact for both signed and unsigned operands.
    prod  = img_x * wgt_x;
    if (signed_mode) begin
      prod_ext = SUM_W'($signed(prod));
      acc_ext  = SUM_W'($signed(acc_in));
    end else begin
      prod_ext = SUM_W'(prod);
      acc_ext  = SUM_W'(acc_in);
    end
    sum = acc_ext + prod_ext;
  end

`ifdef MAU_DBUF_SAT_EN
  // Clamp the guarded sum into the accumulator range
  always_comb begin
    mac_sat = 1'b0;
    mac_res = sum[ACC_W-1:0];
    if (signed_mode) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        mac_sat = 1'b1;
        mac_res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum[ACC_W]) begin
      mac_sat = 1'b1;
      mac_res = {ACC_W{1'b1}};
    end
  end
`else
  // Wrap-around accumulate
  always_comb begin
    mac_sat = 1'b0;
    mac_res = sum;
  end
`endif

  // Next partial sum and forwarded shadow weight
  always_comb begin
    acc_d             = '0;
    acc_valid_d       = 1'b0;
    sat_d             = 1'b0;
    out_weight_d      = '0;
    out_weight_load_d = 1'b0;
    if (in_image_load) begin
      if (act_valid) begin
        acc_d       = mac_res;
        acc_valid_d = 1'b1;
        sat_d       = mac_sat;
      end else begin
        // No active weight: product counts as zero, partial sum passes through.
        acc_d = acc_in;
      end
    end
    if (in_weight_load && shd_valid) begin
      out_weight_d      = shadow_w;
      out_weight_load_d = 1'b1;
    end
  end

  // Weight FSM, banks and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= W_EMPTY;
      bank_sel_q        <= 1'b0;
      bank0_q           <= '0;
      bank1_q           <= '0;
      out_image_q       <= '0;
      out_image_load_q  <= 1'b0;
      out_weight_q      <= '0;
      out_weight_load_q <= 1'b0;
      out_weight_swap_q <= 1'b0;
      acc_out_q         <= '0;
      acc_out_valid_q   <= 1'b0;
      swap_err_q        <= 1'b0;
      sat_flag_q        <= 1'b0;
    end else begin
      if (in_weight_load) begin
        if (bank_sel_q) begin
          bank0_q <= in_weight;
        end else begin
          bank1_q <= in_weight;
        end
      end

      if (swap_ok) begin
        bank_sel_q <= ~bank_sel_q;
        state_q    <= W_ACTIVE;
      end else if (in_weight_load) begin
        case (state_q)
          W_EMPTY:  state_q <= W_SHADOW;
          W_ACTIVE: state_q <= W_FULL;
          default:  state_q <= state_q;
        endcase
      end

      out_image_q       <= in_image_load ? in_image : '0;
      out_image_load_q  <= in_image_load;
      out_weight_q      <= out_weight_d;
      out_weight_load_q <= out_weight_load_d;
      out_weight_swap_q <= in_weight_swap;
      acc_out_q         <= acc_d;
      acc_out_valid_q   <= acc_valid_d;
      swap_err_q        <= swap_bad;
      sat_flag_q        <= sat_d;
    end
  end

  assign out_image       = out_image_q;
  assign out_image_load  = out_image_load_q;
  assign out_weight      = out_weight_q;
  assign out_weight_load = out_weight_load_q;
  assign out_weight_swap = out_weight_swap_q;
  assign acc_out         = acc_out_q;
  assign acc_out_valid   = acc_out_valid_q;
  assign swap_err        = swap_err_q;
  assign sat_flag        = sat_flag_q;
  assign weight_state    = state_q;

endmodule

// File: tb/tb_mau_dbuf.sv
// Testbench for mau_dbuf: directed scenarios followed by random traffic,
// every cycle compared against a value-level model of the weight banks.
module tb_mau_dbuf;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_mode;
  logic [DW-1:0] in_image;
  logic          in_image_load;
  logic [DW-1:0] in_weight;
  logic          in_weight_load;
  logic          in_weight_swap;
  logic [AW-1:0] acc_in;
  logic [DW-1:0] out_image;
  logic          out_image_load;
  logic [DW-1:0] out_weight;
  logic          out_weight_load;
  logic          out_weight_swap;
  logic [AW-1:0] acc_out;
  logic          acc_out_valid;
  logic          swap_err;
  logic          sat_flag;
  logic [1:0]    weight_state;

  mau_dbuf #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .signed_mode(signed_mode),
    .in_image(in_image), .in_image_load(in_image_load),
    .in_weight(in_weight), .in_weight_load(in_weight_load),
    .in_weight_swap(in_weight_swap), .acc_in(acc_in),
    .out_image(out_image), .out_image_load(out_image_load),
    .out_weight(out_weight), .out_weight_load(out_weight_load),
    .out_weight_swap(out_weight_swap), .acc_out(acc_out),
    .acc_out_valid(acc_out_valid), .swap_err(swap_err),
    .sat_flag(sat_flag), .weight_state(weight_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the active and shadow weights as plain values with valid flags
  bit            m_av, m_sv;
  logic [DW-1:0] m_a, m_s;

  // Expected outputs after the next clock edge
  logic [DW-1:0] e_oimg, e_ow;
  logic          e_oil, e_owl, e_osw, e_av, e_err, e_sat;
  logic [AW-1:0] e_acc;
  logic [1:0]    e_st;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint a, w, ac, s;
    longint max_s, min_s, max_u;
    logic [63:0] su;
    max_s = (longint'(1) <<< (AW - 1)) - 1;
    min_s = -(longint'(1) <<< (AW - 1));
    max_u = (longint'(1) <<< AW) - 1;
    if (rst) begin
      m_av = 0; m_sv = 0; m_a = '0; m_s = '0;
      e_oimg = '0; e_oil = 0; e_ow = '0; e_owl = 0; e_osw = 0;
      e_acc = '0; e_av = 0; e_err = 0; e_sat = 0; e_st = 2'd0;
      return;
    end
    e_oimg = in_image_load ? in_image : '0;
    e_oil  = in_image_load;
    e_osw  = in_weight_swap;
    e_sat  = 0;
    e_av   = 0;
    e_acc  = '0;
    // MAC uses the weight that was active before any swap this cycle
    if (in_image_load && m_av) begin
      if (signed_mode) begin
        a  = longint'($signed(in_image));
        w  = longint'($signed(m_a));
        ac = longint'($signed(acc_in));
      end else begin
        a  = longint'(in_image);
        w  = longint'(m_a);
        ac = longint'(acc_in);
      end
      s = ac + a * w;
`ifdef MAU_DBUF_SAT_EN
      if (signed_mode) begin
        if (s > max_s) begin s = max_s; e_sat = 1; end
        else if (s < min_s) begin s = min_s; e_sat = 1; end
      end else if (s > max_u) begin
        s = max_u; e_sat = 1;
      end
`endif
      su    = s;
      e_acc = su[AW-1:0];
      e_av  = 1;
    end else if (in_image_load) begin
      e_acc = acc_in;
    end
    // Load into the shadow slot, displacing any valid shadow down the chain
    e_owl = 0;
    e_ow  = '0;
    if (in_weight_load) begin
      e_owl = m_sv;
      e_ow  = m_sv ? m_s : '0;
      m_s   = in_weight;
      m_sv  = 1;
    end
    e_err = 0;
    if (in_weight_swap) begin
      if (m_sv) begin
        m_a = m_s; m_av = 1; m_sv = 0;
      end else begin
        e_err = 1;
      end
    end
    e_st = {m_av, m_sv};
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("out_image",       64'(out_image),       64'(e_oimg));
    chk("out_image_load",  64'(out_image_load),  64'(e_oil));
    chk("out_weight",      64'(out_weight),      64'(e_ow));
    chk("out_weight_load", 64'(out_weight_load), 64'(e_owl));
    chk("out_weight_swap", 64'(out_weight_swap), 64'(e_osw));
    chk("acc_out",         64'(acc_out),         64'(e_acc));
    chk("acc_out_valid",   64'(acc_out_valid),   64'(e_av));
    chk("swap_err",        64'(swap_err),        64'(e_err));
    chk("sat_flag",        64'(sat_flag),        64'(e_sat));
    chk("weight_state",    64'(weight_state),    64'(e_st));
  endtask

  task automatic drive(input logic r, input logic sm, input logic [DW-1:0] img,
                       input logic il, input logic [DW-1:0] w, input logic wl,
                       input logic sw, input logic [AW-1:0] ai);
    rst = r; signed_mode = sm; in_image = img; in_image_load = il;
    in_weight = w; in_weight_load = wl; in_weight_swap = sw; acc_in = ai;
    cyc();
  endtask

  initial begin
    rst = 1; signed_mode = 0; in_image = '0; in_image_load = 0;
    in_weight = '0; in_weight_load = 0; in_weight_swap = 0; acc_in = '0;

    // Reset, load 3, swap, image 5 + 10 -> 25
    drive(1, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    drive(1, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    chk("tp1_reset_state", 64'(weight_state), 64'd0);
    chk("tp1_reset_acc", 64'(acc_out), 64'd0);
    drive(0, 0, 8'd0, 0, 8'd3, 1, 0, 32'd0);
    chk("tp1_state_shadow", 64'(weight_state), 64'd1);
    drive(0, 0, 8'd0, 0, 8'd0, 0, 1, 32'd0);
    chk("tp1_state_active", 64'(weight_state), 64'd2);
    drive(0, 0, 8'd5, 1, 8'd0, 0, 0, 32'd10);
    chk("tp1_acc", 64'(acc_out), 64'd25);
    chk("tp1_valid", 64'(acc_out_valid), 64'd1);

    // Zero-bubble swap: active 2, stream shadow 7, swap with the third image
    drive(1, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    drive(0, 0, 8'd0, 0, 8'd2, 1, 0, 32'd0);
    drive(0, 0, 8'd0, 0, 8'd0, 0, 1, 32'd0);
    drive(0, 0, 8'd1, 1, 8'd7, 1, 0, 32'd0);
    chk("tp2_acc1", 64'(acc_out), 64'd2);
    drive(0, 0, 8'd1, 1, 8'd0, 0, 0, 32'd0);
    chk("tp2_acc2", 64'(acc_out), 64'd2);
    drive(0, 0, 8'd1, 1, 8'd0, 0, 1, 32'd0);
    chk("tp2_acc3", 64'(acc_out), 64'd2);
    drive(0, 0, 8'd1, 1, 8'd0, 0, 0, 32'd0);
    chk("tp2_acc4", 64'(acc_out), 64'd7);

    // Weight chain: load 4 then 9 forwards 4
    drive(1, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    drive(0, 0, 8'd0, 0, 8'd4, 1, 0, 32'd0);
    drive(0, 0, 8'd0, 0, 8'd9, 1, 0, 32'd0);
    chk("tp3_out_weight", 64'(out_weight), 64'd4);
    chk("tp3_out_weight_load", 64'(out_weight_load), 64'd1);
    chk("tp3_state", 64'(weight_state), 64'd1);

    // Illegal swap in EMPTY with image 5 and acc_in 3
    drive(1, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    drive(0, 0, 8'd5, 1, 8'd0, 0, 1, 32'd3);
    chk("tp4_swap_err", 64'(swap_err), 64'd1);
    chk("tp4_state", 64'(weight_state), 64'd0);
    chk("tp4_valid", 64'(acc_out_valid), 64'd0);
    chk("tp4_acc", 64'(acc_out), 64'd3);
    drive(0, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    chk("tp4_err_pulse", 64'(swap_err), 64'd0);

    // Signed vs unsigned: 0xFF * 0x02
    drive(1, 0, 8'd0, 0, 8'd0, 0, 0, 32'd0);
    drive(0, 0, 8'd0, 0, 8'hFF, 1, 1, 32'd0);
    drive(0, 1, 8'd2, 1, 8'd0, 0, 0, 32'd0);
    chk("tp5_signed", 64'(acc_out), 64'hFFFF_FFFE);
    drive(0, 0, 8'd2, 1, 8'd0, 0, 0, 32'd0);
    chk("tp5_unsigned", 64'(acc_out), 64'h0000_01FE);

    // Overflow at the top of the signed range
    drive(0, 0, 8'd0, 0, 8'd1, 1, 1, 32'd0);
    drive(0, 1, 8'd1, 1, 8'd0, 0, 0, 32'h7FFF_FFFF);
`ifdef MAU_DBUF_SAT_EN
    chk("tp6_acc_sat", 64'(acc_out), 64'h7FFF_FFFF);
    chk("tp6_flag_sat", 64'(sat_flag), 64'd1);
`else
    chk("tp6_acc_wrap", 64'(acc_out), 64'h8000_0000);
    chk("tp6_flag_wrap", 64'(sat_flag), 64'd0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] ai;
      case ($urandom_range(0, 4))
        0:       ai = 32'h7FFF_FFFF;
        1:       ai = 32'h8000_0000;
        2:       ai = 32'hFFFF_FFFF;
        default: ai = $urandom;
      endcase
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 8'($urandom),
            1'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ai);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
